// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit_pkg
// Brief    : Op codes, FSM state type and helpers shared by the mul/div unit.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_unit_pkg;

    localparam logic [2:0] MD_OP_MULT  = 3'b000;
    localparam logic [2:0] MD_OP_MULTU = 3'b001;
    localparam logic [2:0] MD_OP_DIV   = 3'b010;
    localparam logic [2:0] MD_OP_DIVU  = 3'b011;
    localparam logic [2:0] MD_OP_MTHI  = 3'b100;
    localparam logic [2:0] MD_OP_MTLO  = 3'b101;

    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_t;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit_if
// Brief    : EX-stage issue/read bundle between the pipeline and the unit.
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        rd_req;
    logic        rd_sel;
    logic [31:0] rd_data;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, flush, rd_req, rd_sel,
        input  rd_data, busy, stall, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush, rd_req, rd_sel,
        output rd_data, busy, stall, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/md_divider.sv
`default_nettype none
// ============================================================================
// Module   : md_divider
// Brief    : 32-step restoring divider on magnitudes with a final sign fix.
// Revision : 1.0 - initial release
// ============================================================================
module md_divider
    import muldiv_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        signed_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        valid,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic        r_active;
    logic [5:0]  r_cnt;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [32:0] w_shift;
    logic [32:0] w_diff;

    assign w_shift = {r_rem, r_quo[31]};
    assign w_diff  = w_shift - {1'b0, r_div};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_cnt    <= 6'd0;
            r_rem    <= 32'd0;
            r_quo    <= 32'd0;
            r_div    <= 32'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else if (flush) begin
            r_active <= 1'b0;
            r_cnt    <= 6'd0;
        end else if (go) begin
            r_active <= 1'b1;
            r_cnt    <= 6'd0;
            r_rem    <= 32'd0;
            r_quo    <= abs32(a, signed_op);
            r_div    <= abs32(b, signed_op);
            // A zero divisor keeps the all-ones quotient unsigned-looking.
            r_neg_q  <= signed_op && (a[31] ^ b[31]) && (b != 32'd0);
            r_neg_r  <= signed_op && a[31];
        end else if (r_active) begin
            if (r_cnt == 6'(DIV_ITERS)) begin
                r_active <= 1'b0;
                r_cnt    <= 6'd0;
            end else begin
                r_cnt <= r_cnt + 6'd1;
                if (!w_diff[32]) begin
                    r_rem <= w_diff[31:0];
                    r_quo <= {r_quo[30:0], 1'b1};
                end else begin
                    r_rem <= w_shift[31:0];
                    r_quo <= {r_quo[30:0], 1'b0};
                end
            end
        end
    end

    // The sign fix-up cycle: results are presented while the top commits them.
    assign valid     = r_active && (r_cnt == 6'(DIV_ITERS));
    assign quotient  = r_neg_q ? (~r_quo + 32'd1) : r_quo;
    assign remainder = r_neg_r ? (~r_rem + 32'd1) : r_rem;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Multi-cycle multiply/divide unit with HI/LO for the EX stage.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int MUL_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);

    localparam logic [3:0] C_MUL_LOAD = 4'(MUL_CYCLES);

    md_state_t   r_state;
    logic [3:0]  r_cnt;
    logic [63:0] r_prod;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;

    logic        w_accept;
    logic        w_mul_signed;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;
    logic        w_div_go;
    logic        w_div_valid;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_accept     = (r_state == ST_IDLE) && bus.start && !bus.flush;
    assign w_mul_signed = (bus.op == MD_OP_MULT);
    // Sign- or zero-extension lets one 64-bit multiplier serve both flavours.
    assign w_ext_a      = {{32{w_mul_signed & bus.a[31]}}, bus.a};
    assign w_ext_b      = {{32{w_mul_signed & bus.b[31]}}, bus.b};
    assign w_prod       = w_ext_a * w_ext_b;
    assign w_div_go     = w_accept && ((bus.op == MD_OP_DIV) || (bus.op == MD_OP_DIVU));

    md_divider u_div (
        .clk       (clk),
        .rst       (rst),
        .go        (w_div_go),
        .signed_op (bus.op == MD_OP_DIV),
        .a         (bus.a),
        .b         (bus.b),
        .flush     (bus.flush),
        .valid     (w_div_valid),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_prod  <= 64'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (bus.op)
                            MD_OP_MULT, MD_OP_MULTU: begin
                                r_prod  <= w_prod;
                                r_cnt   <= C_MUL_LOAD;
                                r_state <= ST_MUL;
                                r_busy  <= 1'b1;
                            end
                            MD_OP_DIV, MD_OP_DIVU: begin
                                r_state <= ST_DIV;
                                r_busy  <= 1'b1;
                            end
                            MD_OP_MTHI: r_hi <= bus.a;
                            MD_OP_MTLO: r_lo <= bus.a;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (bus.flush) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 4'd0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == 4'd1) begin
                        {r_hi, r_lo} <= r_prod;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_cnt   <= 4'd0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_DIV: begin
                    if (bus.flush) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_div_valid) begin
                        r_hi    <= w_rem;
                        r_lo    <= w_quo;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.hi      = r_hi;
    assign bus.lo      = r_lo;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.stall   = r_busy & (bus.start | bus.rd_req);
    assign bus.rd_data = bus.rd_sel ? r_hi : r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Self-checking bench: latency-level reference model plus directed cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int MUL_CYCLES = 4;
    localparam int DIV_LAT    = 33;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_unit_if bus ();

    muldiv_unit #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model: architectural HI/LO plus cycles left on the pending result.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [63:0] m_pend = 64'd0;
    int          m_left = 0;
    bit          m_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                               input logic [31:0] y);
        longint sp;
        int     q;
        int     r;
        case (o)
            3'd0: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                return 64'(sp);
            end
            3'd1: return {32'd0, x} * {32'd0, y};
            3'd2: begin
                if (y == 32'd0) return {x, 32'hFFFFFFFF};
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {r, q};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFFFFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    task automatic model_reset();
        m_hi = 32'd0; m_lo = 32'd0; m_pend = 64'd0; m_left = 0; m_done = 1'b0;
    endtask

    task automatic model_edge();
        m_done = 1'b0;
        if (m_left > 0) begin
            if (bus.flush) m_left = 0;
            else begin
                m_left--;
                if (m_left == 0) begin
                    {m_hi, m_lo} = m_pend;
                    m_done = 1'b1;
                end
            end
        end else if (bus.start && !bus.flush) begin
            case (bus.op)
                3'd0, 3'd1: begin m_pend = ref_result(bus.op, bus.a, bus.b); m_left = MUL_CYCLES; end
                3'd2, 3'd3: begin m_pend = ref_result(bus.op, bus.a, bus.b); m_left = DIV_LAT; end
                3'd4: m_hi = bus.a;
                3'd5: m_lo = bus.a;
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit s, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input bit fl, input bit rq, input bit rs);
        bus.start = s; bus.op = o; bus.a = x; bus.b = y;
        bus.flush = fl; bus.rd_req = rq; bus.rd_sel = rs;
    endtask

    task automatic idle_in();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_until_done(input string name, output int cycles);
        cycles = 0;
        while (!bus.done && cycles < 100) begin
            tick();
            cycles++;
        end
        if (!bus.done) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 15));
            4: return -32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",    32'(bus.busy), 32'(m_left != 0));
            chk("done",    32'(bus.done), 32'(m_done));
            chk("hi",      bus.hi, m_hi);
            chk("lo",      bus.lo, m_lo);
            chk("stall",   32'(bus.stall), 32'((m_left != 0) && (bus.start || bus.rd_req)));
            chk("rd_data", bus.rd_data, bus.rd_sel ? m_hi : m_lo);
        end
    end

    initial begin
        int  lat;
        bit  saw_done;
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi",   bus.hi, 32'd0);
        chk("rst_lo",   bus.lo, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        model_reset();
        chk_en = 1'b1;

        // Signed multiply: -2 * 3.
        drive(1'b1, 3'd0, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0, 1'b0);
        tick();
        idle_in();
        run_until_done("mult", lat);
        chk("mult_lat", 32'(lat), 32'd4);
        chk("mult_hi", bus.hi, 32'hFFFFFFFF);
        chk("mult_lo", bus.lo, 32'hFFFFFFFA);

        // Unsigned multiply issued in the done cycle (back-to-back).
        drive(1'b1, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        tick();
        idle_in();
        chk("multu_done_once", 32'(bus.done), 32'd0);
        run_until_done("multu", lat);
        chk("multu_lat", 32'(lat), 32'd4);
        chk("multu_hi", bus.hi, 32'hFFFFFFFE);
        chk("multu_lo", bus.lo, 32'h00000001);

        // Signed divide -7 / 2.
        drive(1'b1, 3'd2, -32'd7, 32'd2, 1'b0, 1'b0, 1'b0);
        tick();
        idle_in();
        run_until_done("div", lat);
        chk("div_lat", 32'(lat), 32'd33);
        chk("div_lo", bus.lo, 32'hFFFFFFFD);
        chk("div_hi", bus.hi, 32'hFFFFFFFF);

        // Unsigned divide by zero.
        drive(1'b1, 3'd3, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        idle_in();
        run_until_done("divu0", lat);
        chk("divu0_lo", bus.lo, 32'hFFFFFFFF);
        chk("divu0_hi", bus.hi, 32'd7);

        // mflo waiting on a divide: stall releases in the done cycle with new LO.
        drive(1'b1, 3'd2, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        chk("mflo_stall_on", 32'(bus.stall), 32'd1);
        run_until_done("mflo", lat);
        chk("mflo_stall_off", 32'(bus.stall), 32'd0);
        chk("mflo_rd_data", bus.rd_data, 32'd14);
        idle_in();

        // mthi in IDLE.
        drive(1'b1, 3'd4, 32'h12345678, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        idle_in();
        chk("mthi_hi", bus.hi, 32'h12345678);
        chk("mthi_busy", 32'(bus.busy), 32'd0);

        // Divide aborted by flush mid-flight.
        drive(1'b1, 3'd2, 32'd55, 32'd3, 1'b0, 1'b0, 1'b0);
        tick();
        idle_in();
        repeat (9) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_busy", 32'(bus.busy), 32'd0);
        saw_done = 1'b0;
        repeat (40) begin
            tick();
            if (bus.done) saw_done = 1'b1;
        end
        chk("flush_no_done", 32'(saw_done), 32'd0);
        chk("flush_hi", bus.hi, 32'h12345678);
        chk("flush_lo", bus.lo, 32'd14);

        // flush beats a same-cycle start.
        drive(1'b1, 3'd0, 32'd5, 32'd5, 1'b1, 1'b0, 1'b0);
        tick();
        idle_in();
        chk("flush_start_busy", 32'(bus.busy), 32'd0);

        // Asynchronous reset in the middle of a divide.
        drive(1'b1, 3'd3, 32'd1000, 32'd3, 1'b0, 1'b0, 1'b0);
        tick();
        idle_in();
        repeat (14) tick();
        chk_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_hi", bus.hi, 32'd0);
        chk("arst_lo", bus.lo, 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        drive(1'b1, 3'd0, 32'd6, 32'd7, 1'b0, 1'b0, 1'b0);
        tick();
        idle_in();
        run_until_done("post_rst_mult", lat);
        chk("post_rst_lo", bus.lo, 32'd42);
        chk("post_rst_hi", bus.hi, 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 9) < 4), 3'($urandom_range(0, 7)), pick(), pick(),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 3),
                  1'($urandom_range(0, 1)));
            tick();
        end
        idle_in();
        repeat (40) tick();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers for the EX stage of the 5-stage MIPS pipeline. It executes mult/multu/div/divu/mthi/mtlo issued from ID/EX with forwarded operands. It serves mfhi/mflo reads and raises a stall consumed by the hazard detector, which deasserts PC_Write and IFID_Write and inserts a bubble while a result is outstanding.

## Interface

**Parameters**
- MUL_CYCLES, default 4: cycles from accepted multiply to HI/LO update. Legal range 1..8.

**Ports** (name, direction, width, meaning)
- clk, in, 1: sole clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: EX instruction is a mult/divide/move-to op.
- op, in, 3: `MD_op_mult`=000, `MD_op_multu`=001, `MD_op_div`=010, `MD_op_divu`=011, `MD_op_mthi`=100, `MD_op_mtlo`=101; other codes are ignored (no-op).
- a, in, 32: rs operand, already forwarded.
- b, in, 32: rt operand, already forwarded.
- flush, in, 1: abort the in-flight operation.
- rd_req, in, 1: EX instruction is mfhi/mflo.
- rd_sel, in, 1: 1 selects HI, 0 selects LO.
- rd_data, out, 32: combinational read of the selected HI/LO.
- busy, out, 1: a multiply or divide is in flight.
- stall, out, 1: equals busy & (start | rd_req).
- done, out, 1: one-cycle pulse when HI/LO are updated by a multiply or divide.
- hi, out, 32: HI register.
- lo, out, 32: LO register.

## Operation

**States:** IDLE, MUL, DIV.

**IDLE**, when start is high and flush is low:
- mult/multu: latch operands, load counter with MUL_CYCLES, go to MUL.
- div/divu: latch operands, go to DIV with the iteration counter at 0.
- mthi/mtlo: write a into HI/LO at this edge. State stays IDLE; busy stays low.

**MUL**
- Decrement the counter each cycle.
- When the counter reaches 1: {HI,LO} ← 64-bit product, signed for mult, unsigned for multu. Pulse done, go to IDLE.

**DIV**
- Restoring radix-2 division on magnitudes.
- div: operands are converted to absolute value as 32-bit unsigned magnitudes.
- 32 iteration cycles, then 1 sign-fix cycle.
- Quotient is negated if the operand signs differ. Remainder takes the sign of the dividend.
- Result: LO ← quotient, HI ← remainder. Pulse done, go to IDLE.
- Divide by zero (b==0, signed or unsigned): full latency still applies. Result is LO=32'hFFFFFFFF, HI=a.
- 0x80000000 / -1 (signed) yields LO=0x80000000, HI=0. This falls out of the magnitude arithmetic and needs no special case.

**Concurrency and priority**
- start while busy is not accepted. Stall holds the instruction in EX until busy falls, and it is accepted in the first IDLE cycle.
- flush while busy: state ← IDLE at the next edge. HI/LO are unchanged and no done pulse is produced.
- flush and start in the same cycle: flush wins and start is ignored.
- rd_req in IDLE returns the current HI/LO. A same-cycle start (not produced by the pipeline) does not bypass: rd_data shows pre-edge values.

**Reset** (asynchronous, any state, including mid-divide):
- HI=0, LO=0, state=IDLE, counters=0.
- busy=0, done=0, stall=0.

## Timing

- Edge 0 accepts start.
- busy is high from the cycle after edge 0 through the last compute cycle. It is low in the same cycle done is high.
- Multiply: HI/LO are written at edge MUL_CYCLES. done is high during cycle MUL_CYCLES.
- Divide: HI/LO are written at edge 33. done is high during cycle 33.
- mthi/mtlo: visible on hi/lo and rd_data in cycle 1.
- Back-to-back: a new start is accepted in the done cycle. There are no dead cycles.
- stall and rd_data are purely combinational. There are no registered outputs other than hi, lo, busy, and done.

## Structure

- Add the `MD_op_*` codes to declarations.v next to the ALU and CMP op codes.
- Sub-module md_divider holds the iteration counter, partial remainder/quotient registers, and sign fix-up. Its interface is go, signed_op, a, b, flush → valid, quotient, remainder.
- The multiply path stays in muldiv_unit: a counter plus a single registered `*` product.
- The Controller and HarzardDetector gain decode and stall-OR hooks. Those changes are outside this block.

## Test plan

- mult a=0xFFFFFFFE (-2), b=3, default MUL_CYCLES → busy for 4 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA; done pulses once.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- div a=-7, b=2 → after 33 cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu a=7, b=0 → LO=0xFFFFFFFF, HI=7.
- mflo (rd_req=1, rd_sel=0) issued 1 cycle after a div → stall high for 32 cycles, drops in the done cycle; rd_data=new LO.
- mthi a=0x12345678 in IDLE → hi=0x12345678 next cycle, busy stays 0. Then start div with flush at cycle 10 → busy low from cycle 11; HI/LO unchanged; no done.
- rst asserted mid-divide (cycle 15, asynchronous, between edges) → hi=lo=0, busy=0 immediately; a new mult after release completes normally.
